// File: rtl/aie_noc_pkg.sv
// Shared types and constants for the mini-AIE NoC egress path.
// Header length field location and drain FSM encoding.
package aie_noc_pkg;

   localparam int BYTE_W       = 8;
   localparam int HDR_LEN_LSB  = 0;
   localparam int HDR_LEN_BITS = 4;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SHOW,
      FETCH,
      CSUM
   } drain_state_t;

   function automatic logic [HDR_LEN_BITS-1:0] hdr_len(
      input logic [BYTE_W-1:0] b
   );
      return b[HDR_LEN_LSB +: HDR_LEN_BITS];
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level input,
// followed by a single-cycle rising-edge pulse.
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/noc_egress_drain.sv
// Egress reader for the last NoC switch FIFO: frames header + payload,
// appends an XOR checksum and paces output with a host valid/ready edge.
module noc_egress_drain
   import aie_noc_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int LEN_BITS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  pkt_count
);

   drain_state_t          r_state;
   logic                  r_rd_en;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_last;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_csum;
   logic [LEN_BITS-1:0]   r_rem;
   logic                  r_in_pkt;
   logic                  r_ack_pend;

   logic                  w_ack;
   logic                  w_take;
   logic [LEN_BITS-1:0]   w_len;

   sync_edge_detect #(
      .STAGES(SYNC_STAGES)
   ) u_ready_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (out_ready),
      .o_rise(w_ack)
   );

   // An ack seen while frozen is parked until ena returns.
   assign w_take = ena & r_valid & (w_ack | r_ack_pend);
   assign w_len  = fifo_data[HDR_LEN_LSB +: LEN_BITS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rd_en    <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_cnt      <= '0;
         r_csum     <= '0;
         r_rem      <= '0;
         r_in_pkt   <= 1'b0;
         r_ack_pend <= 1'b0;
      end else begin
         r_rd_en    <= 1'b0;
         r_ack_pend <= r_valid & ~ena & (w_ack | r_ack_pend);
         unique case (r_state)
            IDLE, FETCH: begin
               if (ena && !fifo_empty) begin
                  r_rd_en <= 1'b1;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               // First WAIT cycle covers the FIFO read latency.
               if (!r_rd_en) begin
                  r_data  <= fifo_data;
                  r_valid <= 1'b1;
                  r_state <= SHOW;
                  if (!r_in_pkt) begin
                     r_in_pkt <= 1'b1;
                     r_rem    <= w_len;
                     r_csum   <= fifo_data;
                  end else begin
                     r_rem  <= r_rem - 1'b1;
                     r_csum <= r_csum ^ fifo_data;
                  end
               end
            end
            SHOW: begin
               if (w_take) begin
                  r_valid <= 1'b0;
                  r_state <= (r_rem != '0) ? FETCH : CSUM;
               end
            end
            CSUM: begin
               if (!r_valid) begin
                  if (ena) begin
                     r_data  <= r_csum;
                     r_valid <= 1'b1;
                     r_last  <= 1'b1;
                  end
               end else if (w_take) begin
                  r_valid  <= 1'b0;
                  r_last   <= 1'b0;
                  r_cnt    <= r_cnt + 1'b1;
                  r_in_pkt <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fifo_rd_en = r_rd_en;
   assign out_data   = r_data;
   assign out_valid  = r_valid;
   assign out_last   = r_last;
   assign pkt_count  = r_cnt;

endmodule
